// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: a free-running 16x baud tick drives the receiver.
// The transmitter times its own bits from the start edge.
module uart_top #(
  parameter int DIV = 11
) (
  input  logic       sys_clk,
  input  logic       sys_rst_l,
  output logic       uart_XMIT_dataH,
  input  logic       xmitH,
  input  logic [7:0] xmit_dataH,
  output logic       xmit_doneH,
  input  logic       uart_REC_dataH,
  output logic [7:0] rec_dataH,
  output logic       rec_readyH
);

  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = OVERSAMPLE * DIV;
  localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W      = $clog2(BIT_CLKS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CLKS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  always_ff @(posedge sys_clk or posedge sys_rst_l) begin
    if (sys_rst_l) div_cnt_q <= '0;
    else           div_cnt_q <= div_cnt_d;
  end

  // ---------------- transmitter ----------------
  tx_state_t        tx_state_q, tx_state_d;
  logic [BIT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_bit_end;

  always_ff @(posedge sys_clk or posedge sys_rst_l) begin
    if (sys_rst_l) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // A request seen at the end of a stop bit chains straight into the next start bit.
  always_comb begin
    tx_bit_end = (tx_cnt_q == BIT_LAST);
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + BIT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (xmitH) begin
          tx_state_d = TX_START;
          tx_shift_d = xmit_dataH;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (xmitH) begin
            tx_state_d = TX_START;
            tx_shift_d = xmit_dataH;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_done_d = (tx_state_d == TX_IDLE);
    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  assign uart_XMIT_dataH = tx_line_q;
  assign xmit_doneH      = tx_done_q;

  // ---------------- receiver ----------------
  logic [1:0] sync_q;
  logic       rx_s;
  rx_state_t  rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rec_data_q, rec_data_d;
  logic       rec_ready_q, rec_ready_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge sys_clk or posedge sys_rst_l) begin
    if (sys_rst_l) begin
      sync_q      <= 2'b11;
      rx_state_q  <= RX_IDLE;
      rx_tick_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rec_data_q  <= '0;
      rec_ready_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], uart_REC_dataH};
      rx_state_q  <= rx_state_d;
      rx_tick_q   <= rx_tick_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rec_data_q  <= rec_data_d;
      rec_ready_q <= rec_ready_d;
    end
  end

  // After the mid-start check the 4-bit tick count wraps every bit, so tick 15 is mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_tick_d  = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_tick_q == 4'd7) begin
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_shift_d = {rx_s, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) rx_state_d = rx_s ? RX_IDLE : RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rec_ready_d = (rx_state_q == RX_STOP) && tick && (rx_tick_q == 4'd15) && rx_s;
    rec_data_d  = rec_ready_d ? rx_shift_q : rec_data_q;
  end

  assign rec_dataH  = rec_data_q;
  assign rec_readyH = rec_ready_q;

endmodule

// File: tb/tb_uart_top.sv
// Scoreboard bench for uart_top: randomized TX/RX/loopback traffic checked against
// a frame-level reference model (expected bytes and per-clock line waveform).
module tb_uart_top;
  localparam int DIV = 11;
  localparam int T   = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       xmit_req = 1'b0;
  logic [7:0] xmit_data = 8'h00;
  logic       rx_drive = 1'b1;
  logic       loopback = 1'b0;
  logic       tx_line, xmit_done, rec_ready, rx_line;
  logic [7:0] rec_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_exp;

  always #5 clk = ~clk;

  assign rx_line = loopback ? tx_line : rx_drive;

  uart_top #(.DIV(DIV)) dut (
    .sys_clk        (clk),
    .sys_rst_l      (rst),
    .uart_XMIT_dataH(tx_line),
    .xmitH          (xmit_req),
    .xmit_dataH     (xmit_data),
    .xmit_doneH     (xmit_done),
    .uart_REC_dataH (rx_line),
    .rec_dataH      (rec_data),
    .rec_readyH     (rec_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Request one TX frame; the expected serial frame (and looped-back byte) is queued now.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    xmit_req  = 1'b1;
    xmit_data = b;
    tx_q.push_back(b);
    if (loopback) rx_q.push_back(b);
    @(negedge clk);
    xmit_req  = 1'b0;
    xmit_data = 8'($urandom);
  endtask

  task automatic waitTxIdle(output int n);
    n = 0;
    while (xmit_done !== 1'b1 && n < 12 * T) begin
      @(negedge clk);
      n++;
    end
    if (xmit_done !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL tx_timeout: xmit_doneH=%b after %0d clocks, required 1", xmit_done, n);
    end
  endtask

  task automatic driveRxFrame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) rx_q.push_back(b);
    @(negedge clk);
    rx_drive = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      repeat (T) @(negedge clk);
    end
    rx_drive = stop_bit;
    repeat (T) @(negedge clk);
    rx_drive = 1'b1;
  endtask

  // RX monitor: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rec_ready === 1'b1) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rx_unexpected: got strobe with 0x%0h, required no strobe", rec_data);
      end else begin
        rx_exp = rx_q.pop_front();
        checkOutput("rx_byte", {24'h0, rec_data}, {24'h0, rx_exp});
      end
    end
  end

  // TX monitor: a falling line starts a frame; each of its 10*T clocks is compared
  // to the ideal start/data/stop waveform, and xmit_doneH must stay low throughout.
  initial begin
    logic       prev;
    logic [7:0] exp_b;
    logic [9:0] frame;
    int         bad_line, bad_done, first_bad;
    logic       aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && tx_line === 1'b0) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_unexpected: got a start bit, required idle line");
          exp_b = 8'h00;
        end else begin
          exp_b = tx_q.pop_front();
        end
        frame     = {1'b1, exp_b, 1'b0};
        bad_line  = 0;
        bad_done  = 0;
        first_bad = -1;
        aborted   = 1'b0;
        for (int k = 0; k < 10 * T; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (tx_line !== frame[k / T]) begin
            bad_line++;
            if (first_bad < 0) first_bad = k;
          end
          if (xmit_done !== 1'b0) bad_done++;
        end
        if (aborted) begin
          prev = 1'b1;
        end else begin
          checks++;
          if (bad_line != 0) begin
            errors++;
            $display("[TB] FAIL tx_wave: byte 0x%0h got %0d wrong clocks (first at %0d), required 0", exp_b, bad_line, first_bad);
          end
          checks++;
          if (bad_done != 0) begin
            errors++;
            $display("[TB] FAIL tx_busy: byte 0x%0h got xmit_doneH high on %0d frame clocks, required 0", exp_b, bad_done);
          end
          prev = tx_line;
        end
      end else begin
        prev = tx_line;
      end
    end
  end

  initial begin
    #(800000);
    $display("[TB] FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, n2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_line", {31'h0, tx_line}, 1);
    checkOutput("rst_xmit_done", {31'h0, xmit_done}, 1);
    checkOutput("rst_rec_data", {24'h0, rec_data}, 0);
    checkOutput("rst_rec_ready", {31'h0, rec_ready}, 0);
    rst = 1'b0;
    repeat (T) @(negedge clk);

    $display("[TB] single TX frame 0xA5");
    applyStimulus(8'hA5);
    waitTxIdle(n);
    checkOutput("tx_busy_clks", n, 10 * T);
    checkOutput("tx_done_after", {31'h0, xmit_done}, 1);
    repeat (T) @(negedge clk);

    $display("[TB] RX frame 0x3C");
    driveRxFrame(8'h3C, 1'b1);
    repeat (T) @(negedge clk);
    checkOutput("rx_hold_3c", {24'h0, rec_data}, 8'h3C);

    $display("[TB] reset in the middle of TX and RX frames");
    applyStimulus(8'h96);
    rx_drive = 1'b0;
    repeat (5 * T) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_tx_line", {31'h0, tx_line}, 1);
    checkOutput("midrst_xmit_done", {31'h0, xmit_done}, 1);
    checkOutput("midrst_rec_data", {24'h0, rec_data}, 0);
    checkOutput("midrst_rec_ready", {31'h0, rec_ready}, 0);
    @(negedge clk);
    rx_drive = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * T) @(negedge clk);

    $display("[TB] RX glitch then frame 0xFF");
    @(negedge clk);
    rx_drive = 1'b0;
    repeat (40) @(negedge clk);
    rx_drive = 1'b1;
    repeat (2 * T) @(negedge clk);
    driveRxFrame(8'hFF, 1'b1);
    repeat (T) @(negedge clk);

    $display("[TB] RX frame 0x55 with bad stop bit");
    driveRxFrame(8'h55, 1'b0);
    repeat (2 * T) @(negedge clk);
    checkOutput("rx_keep_after_frame_err", {24'h0, rec_data}, 8'hFF);

    $display("[TB] loopback 0x00 then 0xFF with busy request");
    loopback = 1'b1;
    applyStimulus(8'h00);
    repeat (3 * T) @(negedge clk);
    xmit_req  = 1'b1;
    xmit_data = 8'h5A;
    @(negedge clk);
    xmit_req = 1'b0;
    waitTxIdle(n);
    repeat (T) @(negedge clk);
    applyStimulus(8'hFF);
    waitTxIdle(n);
    checkOutput("loop_busy_clks", n, 10 * T);
    repeat (T) @(negedge clk);
    checkOutput("loop_rec_data", {24'h0, rec_data}, 8'hFF);

    $display("[TB] random concurrent TX and RX traffic");
    loopback = 1'b0;
    for (int r = 0; r < 4; r++) begin
      fork
        begin
          applyStimulus(8'($urandom));
          waitTxIdle(n2);
        end
        begin
          repeat ($urandom_range(0, T)) @(negedge clk);
          driveRxFrame(8'($urandom), ($urandom_range(0, 3) != 0));
        end
      join
      repeat ($urandom_range(T, 2 * T)) @(negedge clk);
    end

    $display("[TB] random loopback traffic");
    loopback = 1'b1;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(8'($urandom));
      waitTxIdle(n);
      repeat ($urandom_range(T, 2 * T)) @(negedge clk);
    end
    loopback = 1'b0;

    repeat (2 * T) @(negedge clk);
    checkOutput("tx_queue_empty", tx_q.size(), 0);
    checkOutput("rx_queue_empty", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
